mem_stage: RTL and testbench

- MEM stage of the 5-stage pipeline. Consumes the EX/MEM register outputs and drives a variable-latency data-memory req/ack handshake.
- Stalls upstream stages while an access is outstanding and resolves the branch decision.
- Selects the writeback value and registers MEM/WB. Its mem_wb_regwrite, mem_wb_rd and mem_wb_rd_data outputs feed back to the EX-stage forwarding unit.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage_mem_wb_reg.sv | 38 +++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding and the bit positions
// inside the EX/MEM control fields.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // control_mem bit positions
    localparam int BR   = 0;
    localparam int RD   = 1;
    localparam int WR   = 2;

    // control_wb bit positions
    localparam int REGW = 0;
    localparam int M2R  = 1;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the
// data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 6
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register. A stalled cycle becomes a bubble: regwrite drops
// while the destination and data keep their previous values.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble,
    input  logic        regwrite_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] rd_data_in,
    output logic        mem_wb_regwrite,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_rd_data
);

    logic        regwrite_r;
    logic [4:0]  rd_r;
    logic [31:0] rd_data_r;

    // pipeline register with synchronous reset and bubble insertion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_r <= 1'b0;
            rd_r       <= 5'd0;
            rd_data_r  <= 32'd0;
        end else if (bubble) begin
            regwrite_r <= 1'b0;
        end else begin
            regwrite_r <= regwrite_in;
            rd_r       <= rd_in;
            rd_data_r  <= rd_data_in;
        end
    end

    assign mem_wb_regwrite = regwrite_r;
    assign mem_wb_rd       = rd_r;
    assign mem_wb_rd_data  = rd_data_r;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory handshake, stalls upstream while an access
// is outstanding, resolves branches and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ex_mem_control_wb,
    input  logic [2:0]  ex_mem_control_mem,
    input  logic [31:0] ex_mem_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic [4:0]  ex_mem_wb_add,
    input  logic        ex_mem_alu_zero,
    mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        pc_src,
    output logic        mem_bus_error,
    output logic        mem_wb_regwrite,
    output logic [4:0]  mem_wb_rd,
    output logic [31:0] mem_wb_rd_data
);

    state_e      state_r;
    state_e      state_next_s;
    logic [3:0]  cnt_r;
    logic        err_r;
    logic        access_s;
    logic        req_s;
    logic        stall_s;
    logic        timeout_s;
    logic        regwrite_in_s;
    logic [31:0] rd_data_in_s;
    logic        unused_s;

    assign access_s = ex_mem_control_mem[RD] | ex_mem_control_mem[WR];
    assign unused_s = ^ex_mem_result[31:ADDR_W];

    // next-state, request and stall decode
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    req_s        = 1'b1;
                    stall_s      = 1'b1;
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                req_s = 1'b1;
                if (dmem.dmem_ack) begin
                    state_next_s = IDLE;
                end else if (cnt_r == 4'(TIMEOUT - 1)) begin
                    timeout_s    = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    stall_s      = 1'b1;
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // wait-cycle counter: zero on entry to WAIT, counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else if (state_r == IDLE) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_r + 4'd1;
        end
    end

    // bus error is a one-cycle pulse following the timed-out completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= timeout_s;
        end
    end

    // Inputs stay stable while stalled, so driving straight from EX/MEM holds the bus.
    assign dmem.dmem_req   = req_s;
    assign dmem.dmem_we    = req_s & ex_mem_control_mem[WR];
    assign dmem.dmem_addr  = ex_mem_result[ADDR_W-1:0];
    assign dmem.dmem_wdata = ex_mem_store_data;

    assign mem_stall     = stall_s;
    assign pc_src        = ex_mem_control_mem[BR] & ex_mem_alu_zero;
    assign mem_bus_error = err_r;

    // Stores never write back; a timed-out access writes back nothing and zero data.
    assign regwrite_in_s = ex_mem_control_wb[REGW] & ~ex_mem_control_mem[WR] & ~timeout_s;
    assign rd_data_in_s  = timeout_s ? 32'd0 :
                           (ex_mem_control_wb[M2R] ? dmem.dmem_rdata : ex_mem_result);

    mem_wb_reg u_mem_wb_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .bubble          (stall_s),
        .regwrite_in     (regwrite_in_s),
        .rd_in           (ex_mem_wb_add),
        .rd_data_in      (rd_data_in_s),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_rd_data  (mem_wb_rd_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, load, store, branch,
// timeout and reset in the middle of an access.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [1:0]  control_wb;
    logic [2:0]  control_mem;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  wb_add;
    logic        alu_zero;
    logic        mem_stall;
    logic        pc_src;
    logic        mem_bus_error;
    logic        mem_wb_regwrite;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_rd_data;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    mem_stage_if #(.ADDR_W(6)) dmem_if ();

    mem_stage #(.ADDR_W(6), .TIMEOUT(15)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_mem_control_wb  (control_wb),
        .ex_mem_control_mem (control_mem),
        .ex_mem_result      (result),
        .ex_mem_store_data  (store_data),
        .ex_mem_wb_add      (wb_add),
        .ex_mem_alu_zero    (alu_zero),
        .dmem               (dmem_if.master),
        .mem_stall          (mem_stall),
        .pc_src             (pc_src),
        .mem_bus_error      (mem_bus_error),
        .mem_wb_regwrite    (mem_wb_regwrite),
        .mem_wb_rd          (mem_wb_rd),
        .mem_wb_rd_data     (mem_wb_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] res,
                          input logic [31:0] sd, input logic [4:0] rd, input logic z);
        control_wb  = wb;
        control_mem = mem;
        result      = res;
        store_data  = sd;
        wb_add      = rd;
        alu_zero    = z;
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_if.dmem_ack   = 1'b0;
        dmem_if.dmem_rdata = 32'd0;
        set_in(2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);

        // reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_req", dmem_if.dmem_req, 32'd0);
        chk("rst_we", dmem_if.dmem_we, 32'd0);
        chk("rst_stall", mem_stall, 32'd0);
        chk("rst_err", mem_bus_error, 32'd0);
        chk("rst_regw", mem_wb_regwrite, 32'd0);
        chk("rst_rd", mem_wb_rd, 32'd0);
        chk("rst_data", mem_wb_rd_data, 32'd0);

        // 1: R-type pass-through
        @(negedge clk);
        rst_n = 1'b1;
        set_in(2'b01, 3'b000, 32'h0000_0025, 32'd0, 5'd8, 1'b0);
        #1;
        chk("rt_req", dmem_if.dmem_req, 32'd0);
        chk("rt_stall", mem_stall, 32'd0);
        @(posedge clk); #1;
        chk("rt_regw", mem_wb_regwrite, 32'd1);
        chk("rt_rd", mem_wb_rd, 32'd8);
        chk("rt_data", mem_wb_rd_data, 32'h25);

        // 4: branch taken / not taken
        @(negedge clk);
        set_in(2'b00, 3'b001, 32'd0, 32'd0, 5'd8, 1'b1);
        #1;
        chk("br_taken", pc_src, 32'd1);
        chk("br_t_req", dmem_if.dmem_req, 32'd0);
        chk("br_t_stall", mem_stall, 32'd0);
        @(negedge clk);
        alu_zero = 1'b0;
        #1;
        chk("br_not", pc_src, 32'd0);
        chk("br_n_req", dmem_if.dmem_req, 32'd0);
        @(posedge clk); #1;
        chk("br_regw", mem_wb_regwrite, 32'd0);

        // 2: load acknowledged three cycles after the request
        @(negedge clk);
        set_in(2'b11, 3'b010, 32'h0000_0010, 32'd0, 5'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_stall", mem_stall, 32'd1);
            chk("ld_req", dmem_if.dmem_req, 32'd1);
            chk("ld_we", dmem_if.dmem_we, 32'd0);
            chk("ld_addr", dmem_if.dmem_addr, 32'h10);
            @(posedge clk); #1;
            chk("ld_bubble", mem_wb_regwrite, 32'd0);
            @(negedge clk);
        end
        dmem_if.dmem_ack   = 1'b1;
        dmem_if.dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_ack_stall", mem_stall, 32'd0);
        @(posedge clk); #1;
        chk("ld_regw", mem_wb_regwrite, 32'd1);
        chk("ld_rd", mem_wb_rd, 32'd3);
        chk("ld_data", mem_wb_rd_data, 32'hDEAD_BEEF);

        // 3: store, regwrite requested but must be suppressed
        @(negedge clk);
        dmem_if.dmem_ack = 1'b0;
        set_in(2'b01, 3'b100, 32'd5, 32'h0000_1234, 5'd9, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("st_stall", mem_stall, 32'd1);
            chk("st_we", dmem_if.dmem_we, 32'd1);
            chk("st_addr", dmem_if.dmem_addr, 32'd5);
            chk("st_wdata", dmem_if.dmem_wdata, 32'h1234);
            @(negedge clk);
        end
        dmem_if.dmem_ack = 1'b1;
        #1;
        chk("st_ack_stall", mem_stall, 32'd0);
        chk("st_ack_we", dmem_if.dmem_we, 32'd1);
        @(posedge clk); #1;
        chk("st_regw", mem_wb_regwrite, 32'd0);

        // 5: load with no acknowledge at all
        @(negedge clk);
        dmem_if.dmem_ack   = 1'b0;
        dmem_if.dmem_rdata = 32'h5555_AAAA;
        set_in(2'b11, 3'b010, 32'h0000_0020, 32'd0, 5'd4, 1'b0);
        n = 0;
        #1;
        while (mem_stall && n < 40) begin
            n++;
            @(posedge clk); #1;
            if (mem_bus_error) chk("to_early_err", mem_bus_error, 32'd0);
            @(negedge clk); #1;
        end
        chk("to_stall_cycles", n, 32'd15);
        chk("to_req_held", dmem_if.dmem_req, 32'd1);
        @(posedge clk); #1;
        chk("to_err", mem_bus_error, 32'd1);
        chk("to_regw", mem_wb_regwrite, 32'd0);
        chk("to_data", mem_wb_rd_data, 32'd0);
        @(negedge clk);
        set_in(2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("to_idle_req", dmem_if.dmem_req, 32'd0);
        @(posedge clk); #1;
        chk("to_err_pulse", mem_bus_error, 32'd0);

        // 6: reset while an access is outstanding, then a stray ack
        @(negedge clk);
        set_in(2'b11, 3'b010, 32'h0000_0011, 32'd0, 5'd5, 1'b0);
        @(negedge clk); #1;
        chk("rm_wait_stall", mem_stall, 32'd1);
        rst_n = 1'b0;
        set_in(2'b00, 3'b000, 32'd0, 32'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        chk("rm_req", dmem_if.dmem_req, 32'd0);
        chk("rm_regw", mem_wb_regwrite, 32'd0);
        chk("rm_rd", mem_wb_rd, 32'd0);
        chk("rm_data", mem_wb_rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_if.dmem_ack   = 1'b1;
        dmem_if.dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk("rm_late_req", dmem_if.dmem_req, 32'd0);
        chk("rm_late_stall", mem_stall, 32'd0);
        @(posedge clk); #1;
        chk("rm_late_regw", mem_wb_regwrite, 32'd0);
        chk("rm_late_data", mem_wb_rd_data, 32'd0);
        @(negedge clk);
        dmem_if.dmem_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
